tmr_fault_monitor: RTL and testbench

Fault monitor that sits directly downstream of the triplicated 32-bit counter and its majority voter. Every enabled cycle it samples the three replica values and the voted value. It keeps per-replica saturating error counts and classifies each replica through a small health state machine: OK, SUSPECT, FAILED. It raises a sticky alarm and a one-cycle interrupt pulse so the system controller can scrub or disable a replica.

---
 rtl/tmr_fault_monitor.sv | 160 ++++++++++++++++
 tb/tb_tmr_fault_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tmr_fault_monitor.sv
// Fault monitor for a triplicated counter and its voter: per-replica error counts,
// a per-replica health FSM, a sticky no-majority flag, an alarm and an interrupt pulse.
module tmr_fault_monitor #(
   parameter int WIDTH        = 32,
   parameter int CNT_W        = 16,
   parameter int FAIL_THRESH  = 4,
   parameter int CLEAN_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clr,
   input  logic [WIDTH-1:0] q_1,
   input  logic [WIDTH-1:0] q_2,
   input  logic [WIDTH-1:0] q_3,
   input  logic [WIDTH-1:0] voted_q,
   output logic [CNT_W-1:0] err_cnt_1,
   output logic [CNT_W-1:0] err_cnt_2,
   output logic [CNT_W-1:0] err_cnt_3,
   output logic [1:0]       state_1,
   output logic [1:0]       state_2,
   output logic [1:0]       state_3,
   output logic             alarm,
   output logic             no_majority,
   output logic             irq
);

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAILED  = 2'd2
   } health_e;

   localparam logic [7:0]       FAIL_T  = 8'(FAIL_THRESH);
   localparam logic [7:0]       CLEAN_T = 8'(CLEAN_CYCLES);
   localparam logic [CNT_W-1:0] ERR_MAX = '1;

   health_e          state_q   [3];
   health_e          state_d   [3];
   logic [CNT_W-1:0] err_q     [3];
   logic [CNT_W-1:0] err_d     [3];
   logic [7:0]       run_q     [3];
   logic [7:0]       run_d     [3];
   logic             run_mis_q [3];
   logic             run_mis_d [3];
   logic [7:0]       run_nx    [3];
   logic             mis       [3];
   logic             alarm_q, alarm_d;
   logic             nm_q, nm_d;
   logic             irq_q, irq_d;
   logic             new_fail;
   logic             nm_sample;

   assign mis[0]    = (q_1 != voted_q);
   assign mis[1]    = (q_2 != voted_q);
   assign mis[2]    = (q_3 != voted_q);
   assign nm_sample = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);

   // Run length after this sample: extends a run of the same kind, else restarts at 1.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         run_nx[i] = (run_mis_q[i] == mis[i]) ? run_q[i] + 8'd1 : 8'd1;
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         state_d[i]   = state_q[i];
         err_d[i]     = err_q[i];
         run_d[i]     = run_q[i];
         run_mis_d[i] = run_mis_q[i];
      end
      nm_d     = nm_q;
      irq_d    = 1'b0;
      new_fail = 1'b0;

      if (clr) begin
         for (int i = 0; i < 3; i++) begin
            state_d[i]   = ST_OK;
            err_d[i]     = '0;
            run_d[i]     = 8'd0;
            run_mis_d[i] = 1'b0;
         end
         nm_d = 1'b0;
      end else if (enable) begin
         for (int i = 0; i < 3; i++) begin
            if (mis[i] && (err_q[i] != ERR_MAX)) begin
               err_d[i] = err_q[i] + 1'b1;
            end
            case (state_q[i])
               ST_OK: begin
                  if (mis[i]) begin
                     state_d[i]   = ST_SUSPECT;
                     run_d[i]     = 8'd1;
                     run_mis_d[i] = 1'b1;
                  end
               end
               ST_SUSPECT: begin
                  run_d[i]     = run_nx[i];
                  run_mis_d[i] = mis[i];
                  if (mis[i] && (run_nx[i] == FAIL_T)) begin
                     state_d[i]   = ST_FAILED;
                     run_d[i]     = 8'd0;
                     run_mis_d[i] = 1'b0;
                     new_fail     = 1'b1;
                  end else if (!mis[i] && (run_nx[i] == CLEAN_T)) begin
                     state_d[i]   = ST_OK;
                     run_d[i]     = 8'd0;
                     run_mis_d[i] = 1'b0;
                  end
               end
               default: begin
               end
            endcase
         end
         if (nm_sample) begin
            nm_d = 1'b1;
         end
         irq_d = new_fail || (nm_sample && !nm_q);
      end

      alarm_d = (state_d[0] == ST_FAILED) || (state_d[1] == ST_FAILED) ||
                (state_d[2] == ST_FAILED);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            state_q[i]   <= ST_OK;
            err_q[i]     <= '0;
            run_q[i]     <= 8'd0;
            run_mis_q[i] <= 1'b0;
         end
         alarm_q <= 1'b0;
         nm_q    <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            state_q[i]   <= state_d[i];
            err_q[i]     <= err_d[i];
            run_q[i]     <= run_d[i];
            run_mis_q[i] <= run_mis_d[i];
         end
         alarm_q <= alarm_d;
         nm_q    <= nm_d;
         irq_q   <= irq_d;
      end
   end

   assign err_cnt_1   = err_q[0];
   assign err_cnt_2   = err_q[1];
   assign err_cnt_3   = err_q[2];
   assign state_1     = state_q[0];
   assign state_2     = state_q[1];
   assign state_3     = state_q[2];
   assign alarm       = alarm_q;
   assign no_majority = nm_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Bench for tmr_fault_monitor: directed scenarios then random samples, compared every
// cycle against a history-based model (default instance plus a CNT_W = 4 instance).
module tb_tmr_fault_monitor;

   localparam int FT = 4;
   localparam int CC = 8;

   logic        clk = 1'b0;
   logic        rst, enable, clr;
   logic [31:0] q_1, q_2, q_3, voted_q;

   logic [15:0] e1, e2, e3;
   logic [1:0]  s1, s2, s3;
   logic        alarm, nm, irq;
   logic [3:0]  se1, se2, se3;
   logic [1:0]  ss1, ss2, ss3;
   logic        salarm, snm, sirq;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state, described in terms of sample history since the last reset/clear.
   int m_total [3];
   int m_mis_run [3];
   int m_match_trail [3];
   bit m_seen [3];
   bit m_failed [3];
   bit m_nm;
   bit m_irq;

   always #5 clk = ~clk;

   tmr_fault_monitor dut (
      .clk(clk), .rst(rst), .enable(enable), .clr(clr),
      .q_1(q_1), .q_2(q_2), .q_3(q_3), .voted_q(voted_q),
      .err_cnt_1(e1), .err_cnt_2(e2), .err_cnt_3(e3),
      .state_1(s1), .state_2(s2), .state_3(s3),
      .alarm(alarm), .no_majority(nm), .irq(irq)
   );

   tmr_fault_monitor #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .enable(enable), .clr(clr),
      .q_1(q_1), .q_2(q_2), .q_3(q_3), .voted_q(voted_q),
      .err_cnt_1(se1), .err_cnt_2(se2), .err_cnt_3(se3),
      .state_1(ss1), .state_2(ss2), .state_3(ss3),
      .alarm(salarm), .no_majority(snm), .irq(sirq)
   );

   function automatic logic [31:0] maj(input logic [31:0] a, b, d);
      return (a & b) | (a & d) | (b & d);
   endfunction

   function automatic logic [1:0] exp_state(input int i);
      if (m_failed[i]) return 2'd2;
      if (!m_seen[i] || m_match_trail[i] >= CC) return 2'd0;
      return 2'd1;
   endfunction

   function automatic logic [31:0] exp_err(input int i, input int maxv);
      return (m_total[i] > maxv) ? 32'(maxv) : 32'(m_total[i]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         m_total[i] = 0; m_mis_run[i] = 0; m_match_trail[i] = 0;
         m_seen[i] = 0; m_failed[i] = 0;
      end
      m_nm  = 0;
      m_irq = 0;
   endtask

   task automatic model_step(input logic r, en, c, input logic [31:0] a, b, d, v);
      logic [31:0] qv [3];
      bit nf, nms;
      qv[0] = a; qv[1] = b; qv[2] = d;
      if (!r || c) begin
         model_clear();
      end else if (!en) begin
         m_irq = 0;
      end else begin
         nf = 0;
         for (int i = 0; i < 3; i++) begin
            if (qv[i] != v) begin
               m_total[i]++;
               m_seen[i] = 1;
               m_match_trail[i] = 0;
               m_mis_run[i]++;
               if (!m_failed[i] && m_mis_run[i] >= FT) begin
                  m_failed[i] = 1;
                  nf = 1;
               end
            end else begin
               m_mis_run[i] = 0;
               if (m_match_trail[i] < 1000) m_match_trail[i]++;
            end
         end
         nms   = (a != b) && (a != d) && (b != d);
         m_irq = nf || (nms && !m_nm);
         if (nms) m_nm = 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("err_cnt_1", 32'(e1), exp_err(0, 65535));
      chk("err_cnt_2", 32'(e2), exp_err(1, 65535));
      chk("err_cnt_3", 32'(e3), exp_err(2, 65535));
      chk("state_1", 32'(s1), 32'(exp_state(0)));
      chk("state_2", 32'(s2), 32'(exp_state(1)));
      chk("state_3", 32'(s3), 32'(exp_state(2)));
      chk("alarm", 32'(alarm), 32'(m_failed[0] | m_failed[1] | m_failed[2]));
      chk("no_majority", 32'(nm), 32'(m_nm));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("sat_err_cnt_1", 32'(se1), exp_err(0, 15));
      chk("sat_err_cnt_2", 32'(se2), exp_err(1, 15));
      chk("sat_err_cnt_3", 32'(se3), exp_err(2, 15));
      chk("sat_alarm", 32'(salarm), 32'(m_failed[0] | m_failed[1] | m_failed[2]));
   endtask

   task automatic cycle(input logic r, en, c, input logic [31:0] a, b, d, v);
      rst = r; enable = en; clr = c;
      q_1 = a; q_2 = b; q_3 = d; voted_q = v;
      @(posedge clk);
      model_step(r, en, c, a, b, d, v);
      #1;
      check_all();
   endtask

   initial begin
      logic [31:0] base, a, b, d;
      int p;
      model_clear();
      // Reset state
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 1, 2, 3, 0);

      // Clean incrementing samples
      for (int k = 0; k < 20; k++) cycle(1, 1, 0, k, k, k, k);

      // Single glitch on replica 2, then recovery
      cycle(1, 1, 0, 100, 100 ^ 32'h1, 100, 100);
      for (int k = 0; k < 8; k++) cycle(1, 1, 0, 200 + k, 200 + k, 200 + k, 200 + k);

      // Replica 3 fails, stays failed
      for (int k = 0; k < 4; k++) cycle(1, 1, 0, 300 + k, 300 + k, 32'hdead_0000 + k, 300 + k);
      for (int k = 0; k < 10; k++) cycle(1, 1, 0, 400 + k, 400 + k, 400 + k, 400 + k);

      // No majority sample
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(1, 1, 0, 5, 6, 9, 1);
      cycle(1, 1, 0, 7, 7, 7, 7);
      cycle(1, 0, 0, 5, 6, 9, 1);

      // Saturation on the narrow instance
      cycle(0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 20; k++) cycle(1, 1, 0, (500 + k) ^ 32'hff, 500 + k, 500 + k, 500 + k);

      // clr wins over the failing sample, then reset mid-operation
      cycle(0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cycle(1, 1, 0, 600 + k, 32'h8000_0000 | k, 600 + k, 600 + k);
      cycle(1, 1, 1, 603, 32'h8000_0003, 603, 603);
      for (int k = 0; k < 3; k++) cycle(1, 1, 0, 610 + k, 32'h8000_0010 | k, 610 + k, 610 + k);
      cycle(0, 1, 0, 620, 621, 620, 620);
      cycle(1, 1, 0, 630, 630, 631, 630);

      // Random samples with varying fault density
      for (int k = 0; k < 600; k++) begin
         p    = (k < 300) ? 2 : 5;
         base = $urandom;
         a = base; b = base; d = base;
         if ($urandom_range(0, 15) < p) a = base ^ (32'h1 << $urandom_range(0, 31));
         if ($urandom_range(0, 15) < p) b = base ^ (32'h1 << $urandom_range(0, 31));
         if ($urandom_range(0, 15) < p) d = base ^ (32'h1 << $urandom_range(0, 31));
         cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 79) == 0), a, b, d, maj(a, b, d));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
